fusion_addr_seq: RTL
====================

Name: fusion_addr_seq

Overview:
Sequencer that sits directly upstream of the spatial-multiplier select generators. It accepts one command per operation: a precision mode and a word count. It then steps the bank address through every sub-word partition the mode requires, one beat per valid/ready handshake. Downstream, each bank's select generator consumes the emitted addr/precision_mode pair, and the accumulation logic consumes the first/last flags.

Parameters:
NUM_BANKS, 4, number of multiplier banks; power of two, >= 2
ADDR_WIDTH, $clog2(NUM_BANKS), width of bank address
MODE_WIDTH, $clog2(ADDR_WIDTH+1), width of precision mode
MAX_MODE, ADDR_WIDTH+1, number of legal precision modes (0..MAX_MODE-1)
COUNT_WIDTH, 16, width of word-count field

Ports:
clk  input  1  clock; all state on rising edge
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns to IDLE
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_mode  input  MODE_WIDTH  precision mode of command
cmd_count  input  COUNT_WIDTH  number of operand words in command
out_valid  output  1  addr beat valid
out_ready  input  1  downstream accepts beat
addr  output  ADDR_WIDTH  bank address for select generators
precision_mode  output  MODE_WIDTH  latched mode of active command
word_first  output  1  beat is first partition of a word (addr==0)
word_last  output  1  beat is last partition of a word
cmd_last  output  1  beat is last beat of the command
done  output  1  one-cycle pulse on command completion

Behaviour:
- States: IDLE, RUN, DONE. Reset (resetn=0, asynchronous) forces:
  - state IDLE
  - addr=0, precision_mode=0, word counter=0
  - out_valid=0, done=0
- cmd_ready = (state==IDLE) && !clear. It is 1 during and after reset.
- Mode handling:
  - Steps per word S = NUM_BANKS >> m, where m is the latched mode.
  - cmd_mode >= MAX_MODE is clamped to MAX_MODE-1 at latch time, so S=1.
  - Only addr[ADDR_WIDTH-m-1:0] varies; upper bits stay 0. For m = MAX_MODE-1, addr stays 0.
- IDLE, command accepted at edge T:
  - Latch the mode and cmd_count.
  - Set addr=0 and word counter=0.
  - If cmd_count!=0, go to RUN: out_valid=1 in cycle T+1.
  - If cmd_count==0, go to DONE with no beats.
- RUN:
  - out_valid=1. All outputs are registered and held stable while out_valid && !out_ready.
  - On a beat (out_valid && out_ready):
    - If addr != S-1, addr increments.
    - Otherwise addr wraps to 0 and the word counter increments.
    - If the beat had cmd_last=1, go to DONE and out_valid=0 next cycle.
- Flags, combinational from registered state:
  - word_first = (addr==0)
  - word_last = (addr==S-1)
  - cmd_last = word_last && (word counter == count-1)
  - With S=1, word_first and word_last are both 1 on every beat.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in DONE, so back-to-back commands are spaced by at least one idle cycle.
- Throughput: one beat per cycle while out_ready=1. Latency from command acceptance to first beat is 1 cycle. Total cycles in RUN = count*S with no stalls.
- clear=1 in any state:
  - Next state IDLE; out_valid=0 and done=0 next cycle.
  - No done pulse is emitted for the aborted command.
  - clear has priority over the handshake. A command presented with clear=1 is not accepted, since cmd_ready=0.
- Reset mid-RUN: asynchronous return to reset values; no beat or done emitted.
- Word counter is COUNT_WIDTH bits. cmd_count = 2^COUNT_WIDTH-1 must complete without overflow.

Test Plan:
1. NUM_BANKS=4. Send mode=0, count=2 with out_ready=1.
   -> 8 beats with addr 0,1,2,3,0,1,2,3.
   -> word_first on beats 1 and 5; word_last on beats 4 and 8; cmd_last only on beat 8.
   -> done=1 the cycle after beat 8; cmd_ready=1 the cycle after that.
2. Send mode=1, count=3.
   -> addr 0,1,0,1,0,1; precision_mode=1 throughout; cmd_last on beat 6.
3. Send mode=2, count=2, then mode=3 (illegal), count=1.
   -> mode=2 gives addr 0,0 with word_first=word_last=1 on both beats.
   -> mode=3 is clamped: precision_mode=2, a single beat with cmd_last=1.
4. Send mode=0, count=1 with out_ready toggling 1,0,0,1,0,1,1.
   -> addr and flags are held stable during stalls.
   -> Exactly 4 beats are accepted; done follows the last accepted beat.
5. Send count=0, accepted at T.
   -> No out_valid; done=1 at T+1; cmd_ready=1 at T+2.
6. Start mode=0, count=4 and assert clear after beat 5.
   -> out_valid=0 and done=0 next cycle, state IDLE.
   -> Repeat the run, this time asserting resetn=0 mid-run: outputs go to reset values immediately; the next command starts at addr 0.

Source files
------------

// File: rtl/fusion_addr_seq_if.sv
// fusion_addr_seq_if: command and beat handshake bundle
// between the fusion address sequencer and its neighbours.
interface fusion_addr_seq_if #(
   parameter int NUM_BANKS   = 4,
   parameter int COUNT_WIDTH = 16
);
   localparam int ADDR_WIDTH = $clog2(NUM_BANKS);
   localparam int MODE_WIDTH = $clog2(ADDR_WIDTH + 1);

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [MODE_WIDTH-1:0]  cmd_mode;
   logic [COUNT_WIDTH-1:0] cmd_count;
   logic                   out_valid;
   logic                   out_ready;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [MODE_WIDTH-1:0]  precision_mode;
   logic                   word_first;
   logic                   word_last;
   logic                   cmd_last;
   logic                   done;

   modport master (
      output cmd_valid, cmd_mode, cmd_count, out_ready,
      input  cmd_ready, out_valid, addr, precision_mode,
      input  word_first, word_last, cmd_last, done
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_count, out_ready,
      output cmd_ready, out_valid, addr, precision_mode,
      output word_first, word_last, cmd_last, done
   );
endinterface

// File: rtl/fusion_addr_seq.sv
// fusion_addr_seq: steps the bank address through every
// sub-word partition of each word of a precision-mode command.
module fusion_addr_seq #(
   parameter int NUM_BANKS   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   fusion_addr_seq_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(NUM_BANKS);
   localparam int MODE_WIDTH = $clog2(ADDR_WIDTH + 1);
   localparam int MAX_MODE   = ADDR_WIDTH + 1;
   localparam int AW1        = ADDR_WIDTH + 1;
   localparam int MW1        = MODE_WIDTH + 1;

   localparam logic [AW1-1:0] BANKS = AW1'(NUM_BANKS);
   localparam logic [MW1-1:0] MAX_M = MW1'(MAX_MODE);
   localparam logic [MODE_WIDTH-1:0] TOP_M = MODE_WIDTH'(MAX_MODE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [MODE_WIDTH-1:0]  mode_q, mode_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] word_q, word_d;

   logic [AW1-1:0]         steps;
   logic [ADDR_WIDTH-1:0]  last_addr;
   logic [MODE_WIDTH-1:0]  mode_in;
   logic                   w_last;
   logic                   c_last;

   // partitions per word shrink by half for each mode step
   always_comb begin
      steps     = BANKS >> mode_q;
      last_addr = ADDR_WIDTH'(steps - AW1'(1));
      w_last    = (addr_q == last_addr);
      c_last    = w_last && (word_q == count_q - COUNT_WIDTH'(1));
      mode_in   = ({1'b0, bus.cmd_mode} >= MAX_M) ? TOP_M : bus.cmd_mode;
   end

   assign bus.cmd_ready      = (state_q == IDLE) && !clear;
   assign bus.out_valid      = (state_q == RUN);
   assign bus.done           = (state_q == DONE);
   assign bus.addr           = addr_q;
   assign bus.precision_mode = mode_q;
   assign bus.word_first     = (addr_q == '0);
   assign bus.word_last      = w_last;
   assign bus.cmd_last       = c_last;

   // next-state and datapath update; clear overrides everything
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mode_d  = mode_q;
      count_d = count_q;
      word_d  = word_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  mode_d  = mode_in;
                  count_d = bus.cmd_count;
                  addr_d  = '0;
                  word_d  = '0;
                  state_d = (bus.cmd_count != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (bus.out_ready) begin
                  if (w_last) begin
                     addr_d = '0;
                     word_d = word_q + COUNT_WIDTH'(1);
                  end else begin
                     addr_d = addr_q + ADDR_WIDTH'(1);
                  end
                  if (c_last) state_d = DONE;
               end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         mode_q  <= '0;
         count_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         word_q  <= word_d;
      end
   end
endmodule
